// File: rtl/mem_port_arbiter_if.sv
// Client and memory-side signal bundle for mem_port_arbiter.
// Handshake: a client raises CH_READ/CH_WRITE with CH_ADDR/CH_WRITEDATA and holds them while its
// CH_BUSYWAIT is high; the single cycle in which its CH_BUSYWAIT is low completes the transfer.
interface mem_port_arbiter_if #(
  parameter int NUM_CH  = 2,
  parameter int ADDR_W  = 28,
  parameter int BLOCK_W = 128
);
  logic [NUM_CH-1:0]         CH_READ;
  logic [NUM_CH-1:0]         CH_WRITE;
  logic [NUM_CH*ADDR_W-1:0]  CH_ADDR;
  logic [NUM_CH*BLOCK_W-1:0] CH_WRITEDATA;
  logic [BLOCK_W-1:0]        CH_READDATA;
  logic [NUM_CH-1:0]         CH_BUSYWAIT;
  logic                      MEM_READ;
  logic                      MEM_WRITE;
  logic [ADDR_W-1:0]         MEM_ADDRESS;
  logic [BLOCK_W-1:0]        MEM_WRITEDATA;
  logic [BLOCK_W-1:0]        MEM_READDATA;
  logic                      MEM_BUSYWAIT;

  modport slave (
    input  CH_READ, CH_WRITE, CH_ADDR, CH_WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
    output CH_READDATA, CH_BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
  );

  modport master (
    output CH_READ, CH_WRITE, CH_ADDR, CH_WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
    input  CH_READDATA, CH_BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// N-channel arbiter sharing one block memory, one outstanding transaction, round-robin grant.
// Define ARB_FIXED_PRIO_EN for fixed priority (lowest requesting index always wins).
module mem_port_arbiter #(
  parameter int NUM_CH  = 2,
  parameter int ADDR_W  = 28,
  parameter int BLOCK_W = 128
) (
  input  logic              CLK,
  input  logic              RESET,
  mem_port_arbiter_if.slave bus,
  output logic [1:0]        dbg_state_o
);
  localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [GW-1:0]      grant_q, grant_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [BLOCK_W-1:0] wdata_q, wdata_d;
  logic [BLOCK_W-1:0] rdata_q, rdata_d;
  logic               rd_q, rd_d;
  logic               wr_q, wr_d;
  logic [NUM_CH-1:0]  req;
  logic [NUM_CH-1:0]  busy;
  logic [GW-1:0]      win;
`ifndef ARB_FIXED_PRIO_EN
  logic [GW-1:0]      ptr_q, ptr_d;
`endif

  assign req = bus.CH_READ | bus.CH_WRITE;

  // Scan from the far end so the last hit is the first channel in priority order.
  always_comb begin : pick_winner
    win = '0;
`ifdef ARB_FIXED_PRIO_EN
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (req[k]) win = GW'(k);
    end
`else
    for (int k = NUM_CH; k >= 1; k--) begin
      if (req[GW'((int'(ptr_q) + k) % NUM_CH)]) win = GW'((int'(ptr_q) + k) % NUM_CH);
    end
`endif
  end

  always_comb begin : busywait_gen
    busy = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      busy[i] = req[i] & ~((state_q == S_DONE) && (grant_q == GW'(i)));
    end
  end

  always_comb begin : fsm_next
    state_d = state_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
`ifndef ARB_FIXED_PRIO_EN
    ptr_d   = ptr_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (|req) begin
          grant_d = win;
          addr_d  = bus.CH_ADDR[int'(win)*ADDR_W +: ADDR_W];
          wdata_d = bus.CH_WRITEDATA[int'(win)*BLOCK_W +: BLOCK_W];
          // Read and write together count as a write.
          wr_d    = bus.CH_WRITE[win];
          rd_d    = ~bus.CH_WRITE[win];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (!bus.MEM_BUSYWAIT) begin
          if (rd_q) rdata_d = bus.MEM_READDATA;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
`ifndef ARB_FIXED_PRIO_EN
        ptr_d   = grant_q;
`endif
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
      ptr_q   <= GW'(NUM_CH - 1);
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
`ifndef ARB_FIXED_PRIO_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign bus.CH_BUSYWAIT   = busy;
  assign bus.CH_READDATA   = rdata_q;
  assign bus.MEM_READ      = rd_q;
  assign bus.MEM_WRITE     = wr_q;
  assign bus.MEM_ADDRESS   = addr_q;
  assign bus.MEM_WRITEDATA = wdata_q;
  assign dbg_state_o       = state_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: random client batches, behavioural memory and a
// reference model predicting grant order, memory traffic, read data and completion cycle.
module tb_mem_port_arbiter;
  localparam int NUM_CH  = 2;
  localparam int ADDR_W  = 28;
  localparam int BLOCK_W = 128;
  localparam int EW      = 8 + 1 + ADDR_W + 2*BLOCK_W + 16;
  localparam int MAX_LAT = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;
  int         cyc = 0;
  int         vectors = 0;
  int         miscompares = 0;

  logic [EW-1:0] exp_q[$];
  int            lat_q[$];

  logic [BLOCK_W-1:0] ref_mem[logic [ADDR_W-1:0]];
  logic [BLOCK_W-1:0] dev_mem[logic [ADDR_W-1:0]];
  logic [BLOCK_W-1:0] ref_last_rd;
  int                 ref_ptr;
  logic               mem_cur_write = 1'b0;

  bit                 b_write[NUM_CH];
  bit                 b_both[NUM_CH];
  logic [ADDR_W-1:0]  b_addr[NUM_CH];
  logic [BLOCK_W-1:0] b_wdata[NUM_CH];
  int                 b_lat[NUM_CH];

  mem_port_arbiter_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .BLOCK_W(BLOCK_W)) bus ();

  mem_port_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .BLOCK_W(BLOCK_W)) dut (
    .CLK         (clk),
    .RESET       (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- model helpers ----------------
  function automatic logic [BLOCK_W-1:0] init_val(input logic [ADDR_W-1:0] a);
    logic [31:0] w;
    w = {4'h0, a};
    return {w ^ 32'hA5A5_0000, ~w, w + 32'h0101_0101, w};
  endfunction

  function automatic logic [BLOCK_W-1:0] ref_rd(input logic [ADDR_W-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  function automatic logic [BLOCK_W-1:0] dev_rd(input logic [ADDR_W-1:0] a);
    return dev_mem.exists(a) ? dev_mem[a] : init_val(a);
  endfunction

  task automatic check(input string name, input logic [EW-1:0] got, input logic [EW-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------- behavioural memory ----------------
  initial begin : memory
    bit active;
    int lat_left;
    logic [ADDR_W-1:0] cur_addr;
    active = 1'b0;
    lat_left = 0;
    cur_addr = '0;
    bus.MEM_BUSYWAIT = 1'b0;
    bus.MEM_READDATA = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        active = 1'b0;
        lat_left = 0;
        bus.MEM_BUSYWAIT = 1'b0;
      end else if (!active) begin
        if (bus.MEM_READ || bus.MEM_WRITE) begin
          active = 1'b1;
          mem_cur_write = bus.MEM_WRITE;
          cur_addr = bus.MEM_ADDRESS;
          lat_left = (lat_q.size() > 0) ? lat_q.pop_front() : 0;
          bus.MEM_READDATA = bus.MEM_READ ? dev_rd(cur_addr) : {$urandom, $urandom, $urandom, $urandom};
          bus.MEM_BUSYWAIT = 1'b1;  // still registering the request; must be ignored
        end
      end else if (!(bus.MEM_READ || bus.MEM_WRITE)) begin
        if (mem_cur_write) dev_mem[cur_addr] = bus.MEM_WRITEDATA;
        active = 1'b0;
        bus.MEM_BUSYWAIT = 1'b0;
      end else begin
        bus.MEM_BUSYWAIT = (lat_left != 0);
        if (lat_left > 0) lat_left--;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    logic [EW-1:0] got;
    logic [NUM_CH-1:0] req;
    forever begin
      @(negedge clk);
      if (!rst) begin
        req = bus.CH_READ | bus.CH_WRITE;
        check("bw_without_req", EW'(bus.CH_BUSYWAIT & ~req), '0);
        for (int c = 0; c < NUM_CH; c++) begin
          if (req[c] && !bus.CH_BUSYWAIT[c]) begin
            got = {8'(c), mem_cur_write, bus.MEM_ADDRESS, bus.MEM_WRITEDATA, bus.CH_READDATA, 16'(cyc)};
            if (exp_q.size() == 0) check("unexpected_done", got, '0);
            else check("txn", got, exp_q.pop_front());
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic fill_random(input bit zero_lat);
    for (int c = 0; c < NUM_CH; c++) begin
      b_write[c] = ($urandom_range(0, 1) == 1);
      b_both[c]  = ($urandom_range(0, 3) == 0);
      b_addr[c]  = ADDR_W'(32'h100 + $urandom_range(0, 7));
      b_wdata[c] = {$urandom, $urandom, $urandom, $urandom};
      b_lat[c]   = zero_lat ? 0 : int'($urandom_range(0, MAX_LAT));
    end
  endtask

  task automatic drive_ch(input int c);
    bus.CH_READ[c]  = !b_write[c] || b_both[c];
    bus.CH_WRITE[c] = b_write[c];
    bus.CH_ADDR[c*ADDR_W +: ADDR_W]        = b_addr[c];
    bus.CH_WRITEDATA[c*BLOCK_W +: BLOCK_W] = b_wdata[c];
  endtask

  task automatic drop_ch(input int c);
    bus.CH_READ[c]  = 1'b0;
    bus.CH_WRITE[c] = 1'b0;
  endtask

  // Call right after a negedge with the arbiter idle.
  task automatic apply_batch(input logic [NUM_CH-1:0] mask, input bit hold_extra);
    int order[$];
    logic [NUM_CH-1:0] left, pending, held;
    int p, w, j, t_exp, budget;
    logic [BLOCK_W-1:0] rd;
    #2;
    left = mask;
    p = ref_ptr;
    while (left != '0) begin
      w = -1;
      for (int k = 1; k <= NUM_CH; k++) begin
`ifdef ARB_FIXED_PRIO_EN
        j = k - 1;
`else
        j = (p + k) % NUM_CH;
`endif
        if (w < 0 && left[j]) w = j;
      end
      order.push_back(w);
      left[w] = 1'b0;
      p = w;
    end
    ref_ptr = p;
    t_exp = cyc;
    foreach (order[n]) begin
      w = order[n];
      t_exp += (n == 0) ? 3 + b_lat[w] : 4 + b_lat[w];
      if (b_write[w]) begin
        rd = ref_last_rd;
        ref_mem[b_addr[w]] = b_wdata[w];
      end else begin
        rd = ref_rd(b_addr[w]);
        ref_last_rd = rd;
      end
      exp_q.push_back({8'(w), b_write[w], b_addr[w], b_wdata[w], rd, 16'(t_exp)});
      lat_q.push_back(b_lat[w]);
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (mask[c]) drive_ch(c);
      else begin
        bus.CH_ADDR[c*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
        bus.CH_WRITEDATA[c*BLOCK_W +: BLOCK_W] = {$urandom, $urandom, $urandom, $urandom};
      end
    end
    pending = mask;
    held = '0;
    budget = NUM_CH * (6 + MAX_LAT) + 20;
    while ((pending | held) != '0 && budget > 0) begin
      @(negedge clk);
      #2;
      budget--;
      for (int c = 0; c < NUM_CH; c++) begin
        if (held[c]) begin
          check("bw_one_cycle", EW'(bus.CH_BUSYWAIT[c]), EW'(1));
          drop_ch(c);
          held[c] = 1'b0;
        end else if (pending[c] && !bus.CH_BUSYWAIT[c]) begin
          pending[c] = 1'b0;
          if (hold_extra) held[c] = 1'b1;
          else drop_ch(c);
        end
      end
    end
    if ((pending | held) != '0) begin
      check("batch_timeout", EW'(pending | held), '0);
      for (int c = 0; c < NUM_CH; c++) drop_ch(c);
      exp_q.delete();
      lat_q.delete();
    end
  endtask

  task automatic gap(input int lo, input int hi);
    repeat ($urandom_range(lo, hi)) @(negedge clk);
  endtask

  task automatic wait_state(input logic [1:0] s, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (dbg_state != s && n < 30);
    check(name, EW'(dbg_state), EW'(s));
  endtask

  task automatic single_read_ch1(input int lat);
    fill_random(1'b0);
    b_write[1] = 1'b0;
    b_both[1]  = 1'b0;
    lat_q.push_back(lat);
    drive_ch(1);
  endtask

  // ---------------- stimulus ----------------
  initial begin : stimulus
    logic [NUM_CH-1:0] mask;
    bus.CH_READ = '0;
    bus.CH_WRITE = '0;
    bus.CH_ADDR = '0;
    bus.CH_WRITEDATA = '0;
    ref_ptr = NUM_CH - 1;
    ref_last_rd = '0;

    repeat (3) @(negedge clk);
    check("rst_mem_read", EW'(bus.MEM_READ), '0);
    check("rst_mem_write", EW'(bus.MEM_WRITE), '0);
    check("rst_mem_addr", EW'(bus.MEM_ADDRESS), '0);
    check("rst_mem_wdata", EW'(bus.MEM_WRITEDATA), '0);
    check("rst_ch_rdata", EW'(bus.CH_READDATA), '0);
    check("rst_state", EW'(dbg_state), '0);
    #2 rst = 1'b0;

    // single read, slow memory, request held one cycle past completion
    @(negedge clk);
    fill_random(1'b0);
    b_write[1] = 1'b0;
    b_both[1]  = 1'b0;
    b_addr[1]  = 28'h0000010;
    b_lat[1]   = 5;
    apply_batch(NUM_CH'(2), 1'b1);

    // both channels requesting back to back
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      fill_random(1'b0);
      apply_batch('1, 1'b0);
    end

    // zero-wait memory
    for (int n = 0; n < 4; n++) begin
      gap(1, 2);
      fill_random(1'b1);
      mask = NUM_CH'($urandom_range(1, (1 << NUM_CH) - 1));
      apply_batch(mask, 1'b0);
    end

    for (int n = 0; n < 25; n++) begin
      gap(1, 3);
      fill_random(1'b0);
      mask = NUM_CH'($urandom_range(1, (1 << NUM_CH) - 1));
      apply_batch(mask, 1'b0);
    end

    // granted channel abandons its read while memory is busy
    gap(1, 2);
    #2;
    single_read_ch1(3);
`ifndef ARB_FIXED_PRIO_EN
    ref_ptr = 1;
`endif
    ref_last_rd = ref_rd(b_addr[1]);
    wait_state(2'd2, "drop_reach_wait");
    #2 drop_ch(1);
    wait_state(2'd3, "drop_reach_done");
    check("drop_bw", EW'(bus.CH_BUSYWAIT), '0);

    for (int n = 0; n < 6; n++) begin
      gap(1, 3);
      fill_random(1'b0);
      mask = NUM_CH'($urandom_range(1, (1 << NUM_CH) - 1));
      apply_batch(mask, 1'b0);
    end

    // reset while waiting on memory
    gap(1, 2);
    #2;
    single_read_ch1(5);
    wait_state(2'd2, "rst_reach_wait");
    #2 rst = 1'b1;
    #1;
    check("midrst_mem_read", EW'(bus.MEM_READ), '0);
    check("midrst_mem_write", EW'(bus.MEM_WRITE), '0);
    check("midrst_mem_addr", EW'(bus.MEM_ADDRESS), '0);
    check("midrst_mem_wdata", EW'(bus.MEM_WRITEDATA), '0);
    check("midrst_ch_rdata", EW'(bus.CH_READDATA), '0);
    check("midrst_state", EW'(dbg_state), '0);
    check("midrst_busywait", EW'(bus.CH_BUSYWAIT), EW'(2));
    for (int c = 0; c < NUM_CH; c++) drop_ch(c);
    exp_q.delete();
    lat_q.delete();
    ref_ptr = NUM_CH - 1;
    ref_last_rd = '0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;

    // simultaneous read on ch0 and write on ch1 straight after reset
    @(negedge clk);
    fill_random(1'b0);
    b_write[0] = 1'b0;
    b_both[0]  = 1'b0;
    b_write[1] = 1'b1;
    apply_batch('1, 1'b0);

    for (int n = 0; n < 6; n++) begin
      gap(1, 3);
      fill_random(1'b0);
      mask = NUM_CH'($urandom_range(1, (1 << NUM_CH) - 1));
      apply_batch(mask, 1'b0);
    end

    repeat (4) @(negedge clk);
    check("exp_q_drained", EW'(exp_q.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
